// File: rtl/axicb_pkg.sv
// Shared types for the crossbar write switches: BRESP codes, the AW
// arbitration state, and the master-index width helper.
package axicb_pkg;

    localparam logic [1:0] BRESP_OKAY   = 2'b00;
    localparam logic [1:0] BRESP_SLVERR = 2'b10;
    localparam logic [1:0] BRESP_DECERR = 2'b11;

    typedef enum logic {ARB, HOLD} sw_state_e;

    function automatic int mst_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axicb_mst_wr_rr_arb.sv
// Round-robin arbiter: first requester at or after the pointer wins.
// i_freeze replays the last unfrozen grant; i_adv moves the pointer past it.
module axicb_mst_wr_rr_arb
    import axicb_pkg::*;
#(
    parameter  int REQ_NB = 4,
    localparam int IDX_W  = mst_idx_w(REQ_NB)
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              srst,
    input  logic [REQ_NB-1:0] i_req,
    input  logic              i_freeze,
    input  logic              i_adv,
    output logic [REQ_NB-1:0] o_gnt,
    output logic [IDX_W-1:0]  o_gnt_idx,
    output logic              o_gnt_vld
);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_hold_idx;
    logic             r_hold_vld;
    logic [IDX_W-1:0] w_arb_idx;
    logic             w_arb_vld;

    always_comb begin
        int j;
        j         = 0;
        w_arb_idx = '0;
        w_arb_vld = 1'b0;
        for (int k = 0; k < REQ_NB; k++) begin
            j = (int'(r_ptr) + k) % REQ_NB;
            if (!w_arb_vld && i_req[j]) begin
                w_arb_vld = 1'b1;
                w_arb_idx = IDX_W'(j);
            end
        end
    end

    assign o_gnt_idx = i_freeze ? r_hold_idx : w_arb_idx;
    assign o_gnt_vld = i_freeze ? r_hold_vld : w_arb_vld;

    always_comb begin
        o_gnt = '0;
        for (int m = 0; m < REQ_NB; m++)
            o_gnt[m] = o_gnt_vld && (o_gnt_idx == IDX_W'(m));
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_ptr      <= '0;
            r_hold_idx <= '0;
            r_hold_vld <= 1'b0;
        end else if (srst) begin
            r_ptr      <= '0;
            r_hold_idx <= '0;
            r_hold_vld <= 1'b0;
        end else begin
            if (!i_freeze) begin
                r_hold_idx <= w_arb_idx;
                r_hold_vld <= w_arb_vld;
            end
            if (i_adv)
                r_ptr <= (int'(o_gnt_idx) == REQ_NB-1) ? '0 : o_gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/axicb_scfifo.sv
// Single-clock FIFO, 2**DEPTH_W entries. PASS_THRU!=0 lets a push be seen
// at the head in the same cycle when the FIFO is empty.
module axicb_scfifo #(
    parameter int DEPTH_W   = 3,
    parameter int DATA_W    = 8,
    parameter int PASS_THRU = 0
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              srst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_full,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic              o_empty
);

    localparam int DEPTH = 1 << DEPTH_W;

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [DEPTH_W-1:0] r_wptr;
    logic [DEPTH_W-1:0] r_rptr;
    logic [DEPTH_W:0]   r_cnt;
    logic               w_cnt_zero;
    logic               w_bypass;
    logic               w_wr;
    logic               w_rd;

    assign w_cnt_zero = (r_cnt == '0);

    generate
        if (PASS_THRU != 0) begin : g_pt
            assign w_bypass = w_cnt_zero && i_push;
        end else begin : g_reg
            assign w_bypass = 1'b0;
        end
    endgenerate

    assign o_full  = (r_cnt == (DEPTH_W+1)'(DEPTH));
    assign o_empty = w_cnt_zero && !w_bypass;
    assign o_data  = w_cnt_zero ? i_data : r_mem[r_rptr];

    // A bypassed push that is popped in the same cycle never touches storage
    assign w_wr = i_push && !o_full && !(w_bypass && i_pop);
    assign w_rd = i_pop && !w_cnt_zero;

    always_ff @(posedge aclk) begin
        if (w_wr)
            r_mem[r_wptr] <= i_data;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else if (srst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_wr)
                r_wptr <= r_wptr + 1'b1;
            if (w_rd)
                r_rptr <= r_rptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/axicb_mst_switch_wr.sv
// Per-slave write switch: RR-arbitrated AW, W steered in AW-grant order via
// an index FIFO, B routed by BID. AXICB_MST_SW_WR_AWREG_EN adds an AW skid slice.
module axicb_mst_switch_wr
    import axicb_pkg::*;
#(
    parameter int MST_NB        = 4,
    parameter int AXI_ADDR_W    = 8,
    parameter int AXI_ID_W      = 8,
    parameter int AWCH_W        = 8,
    parameter int WCH_W         = 8,
    parameter int BCH_W         = AXI_ID_W + 2,
    parameter int WFIFO_DEPTH_W = 3
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     srst,
    input  logic [MST_NB-1:0]        i_awvalid,
    output logic [MST_NB-1:0]        i_awready,
    input  logic [MST_NB*AWCH_W-1:0] i_awch,
    input  logic [MST_NB-1:0]        i_wvalid,
    output logic [MST_NB-1:0]        i_wready,
    input  logic [MST_NB-1:0]        i_wlast,
    input  logic [MST_NB*WCH_W-1:0]  i_wch,
    output logic [MST_NB-1:0]        i_bvalid,
    input  logic [MST_NB-1:0]        i_bready,
    output logic [BCH_W-1:0]         i_bch,
    output logic                     o_awvalid,
    input  logic                     o_awready,
    output logic [AWCH_W-1:0]        o_awch,
    output logic                     o_wvalid,
    input  logic                     o_wready,
    output logic                     o_wlast,
    output logic [WCH_W-1:0]         o_wch,
    input  logic                     o_bvalid,
    output logic                     o_bready,
    input  logic [BCH_W-1:0]         o_bch
);

    localparam int IDX_W = mst_idx_w(MST_NB);

    generate
        if (AWCH_W < AXI_ADDR_W) begin : g_bad_awch
            $error("AWCH_W is narrower than the AW address field");
        end
    endgenerate

    sw_state_e         r_state, w_state_nxt;
    logic [MST_NB-1:0] w_gnt;
    logic [IDX_W-1:0]  w_gidx;
    logic              w_gvld;
    logic              w_freeze;
    logic              w_req_vld;
    logic [AWCH_W-1:0] w_up_ch;
    logic              w_up_valid;
    logic              w_up_ready;
    logic              w_aw_hs;
    logic              w_wf_full;
    logic              w_wf_empty;
    logic              w_wf_pop;
    logic [IDX_W-1:0]  w_wf_head;
    logic [IDX_W-1:0]  w_bidx;

    axicb_mst_wr_rr_arb #(.REQ_NB(MST_NB)) u_arb (
        .aclk      (aclk),
        .areset    (areset),
        .srst      (srst),
        .i_req     (i_awvalid),
        .i_freeze  (w_freeze),
        .i_adv     (w_aw_hs),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gidx),
        .o_gnt_vld (w_gvld)
    );

    always_comb begin
        w_up_ch   = '0;
        w_req_vld = 1'b0;
        for (int m = 0; m < MST_NB; m++) begin
            if (w_gidx == IDX_W'(m)) begin
                w_up_ch   = i_awch[m*AWCH_W +: AWCH_W];
                w_req_vld = i_awvalid[m];
            end
        end
    end

    // A full W-routing FIFO hides the request entirely so no AW escapes unrecorded
    assign w_up_valid = w_gvld && w_req_vld && !w_wf_full;
    assign w_aw_hs    = w_up_valid && w_up_ready;
    assign i_awready  = w_gnt & {MST_NB{w_up_ready && !w_wf_full}};

    always_ff @(posedge aclk or posedge areset) begin
        if (areset)
            r_state <= ARB;
        else if (srst)
            r_state <= ARB;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_freeze    = 1'b0;
        case (r_state)
            ARB: begin
                if (w_up_valid && !w_up_ready)
                    w_state_nxt = HOLD;
            end
            HOLD: begin
                w_freeze = 1'b1;
                if (w_aw_hs)
                    w_state_nxt = ARB;
            end
            default: w_state_nxt = ARB;
        endcase
    end

`ifdef AXICB_MST_SW_WR_AWREG_EN
    logic [1:0]        r_sk_cnt;
    logic [AWCH_W-1:0] r_sk_d0;
    logic [AWCH_W-1:0] r_sk_d1;
    logic              w_sk_pop;

    assign w_up_ready = (r_sk_cnt != 2'd2);
    assign w_sk_pop   = o_awready && (r_sk_cnt != 2'd0);
    assign o_awvalid  = (r_sk_cnt != 2'd0);
    assign o_awch     = r_sk_d0;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_sk_cnt <= 2'd0;
            r_sk_d0  <= '0;
            r_sk_d1  <= '0;
        end else if (srst) begin
            r_sk_cnt <= 2'd0;
            r_sk_d0  <= '0;
            r_sk_d1  <= '0;
        end else begin
            case ({w_aw_hs, w_sk_pop})
                2'b10: begin
                    if (r_sk_cnt == 2'd0)
                        r_sk_d0 <= w_up_ch;
                    else
                        r_sk_d1 <= w_up_ch;
                    r_sk_cnt <= r_sk_cnt + 2'd1;
                end
                2'b01: begin
                    r_sk_d0  <= r_sk_d1;
                    r_sk_cnt <= r_sk_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_sk_cnt == 2'd1) begin
                        r_sk_d0 <= w_up_ch;
                    end else begin
                        r_sk_d0 <= r_sk_d1;
                        r_sk_d1 <= w_up_ch;
                    end
                end
                default: r_sk_cnt <= r_sk_cnt;
            endcase
        end
    end
`else
    assign w_up_ready = o_awready;
    assign o_awvalid  = w_up_valid;
    assign o_awch     = w_up_ch;
`endif

    axicb_scfifo #(
        .DEPTH_W   (WFIFO_DEPTH_W),
        .DATA_W    (IDX_W),
        .PASS_THRU (0)
    ) u_wfifo (
        .aclk    (aclk),
        .areset  (areset),
        .srst    (srst),
        .i_push  (w_aw_hs),
        .i_data  (w_gidx),
        .o_full  (w_wf_full),
        .i_pop   (w_wf_pop),
        .o_data  (w_wf_head),
        .o_empty (w_wf_empty)
    );

    always_comb begin
        o_wvalid = 1'b0;
        o_wlast  = 1'b0;
        o_wch    = '0;
        i_wready = '0;
        for (int m = 0; m < MST_NB; m++) begin
            if (w_wf_head == IDX_W'(m)) begin
                o_wvalid    = i_wvalid[m] && !w_wf_empty;
                o_wlast     = i_wlast[m];
                o_wch       = i_wch[m*WCH_W +: WCH_W];
                i_wready[m] = o_wready && !w_wf_empty;
            end
        end
    end

    assign w_wf_pop = o_wvalid && o_wready && o_wlast;

    // BIDs naming no existing master are sunk here so the slave never stalls
    assign w_bidx = o_bch[AXI_ID_W-1 -: IDX_W];
    assign i_bch  = o_bch;

    always_comb begin
        i_bvalid = '0;
        o_bready = 1'b1;
        for (int m = 0; m < MST_NB; m++) begin
            if (w_bidx == IDX_W'(m)) begin
                i_bvalid[m] = o_bvalid;
                o_bready    = i_bready[m];
            end
        end
    end

endmodule

// File: doc/axicb_mst_switch_wr.md
# axicb_mst_switch_wr

Per-slave write switch sitting directly downstream of the per-master write switches: collects the MST_NB per-master AW/W requests aimed at one slave, arbitrates AW round-robin, and steers W beats in AW-grant order. It routes each B response back to the originating master by decoding BID. One instance per slave port of the crossbar.

## Interface
- MST_NB, 4: number of masters (2..8).
- AXI_ADDR_W, 8: address width; AWCH addr field at [0+:AXI_ADDR_W].
- AXI_ID_W, 8: ID width; AWCH ID at [AXI_ADDR_W+:AXI_ID_W]; upper $clog2(MST_NB) ID bits = master index.
- AWCH_W, 8 / WCH_W, 8: concatenated AW / W channel widths.
- BCH_W, AXI_ID_W+2: B channel = {bresp[1:0], bid}.
- WFIFO_DEPTH_W, 3: log2 depth of the W-routing FIFO.
- aclk  in  1  clock.
- areset  in  1  asynchronous active-high reset.
- srst  in  1  synchronous active-high clear, same effect as areset.
- i_awvalid / i_awready  in / out  MST_NB  per-master AW handshake.
- i_awch  in  MST_NB*AWCH_W  per-master AW payload.
- i_wvalid / i_wready / i_wlast  in / out / in  MST_NB  per-master W handshake.
- i_wch  in  MST_NB*WCH_W  per-master W payload.
- i_bvalid / i_bready  out / in  MST_NB  per-master B handshake.
- i_bch  out  BCH_W  B payload, broadcast to all masters.
- o_awvalid / o_awready / o_awch  out / in / out  1 / 1 / AWCH_W  slave AW.
- o_wvalid / o_wready / o_wlast / o_wch  out / in / out / out  1 / 1 / 1 / WCH_W  slave W.
- o_bvalid / o_bready / o_bch  in / out / in  1 / 1 / BCH_W  slave B.

## Operation
- Reset: all ready/valid outputs 0, arbiter pointer = master 0 highest priority, FSM = ARB, FIFO empty. o_awch/o_wch/i_bch are don't-care while their valid is low.
- AW FSM, ARB: grant = first requesting master at or after pointer (circular). o_awvalid = granted i_awvalid & !wfifo_full. Handshake -> stay ARB, pointer = grant+1 mod MST_NB. Valid & !o_awready -> HOLD.
- HOLD: grant frozen, no re-arbitration, even if other masters assert valid. Handshake -> ARB and pointer update.
- i_awready[m] = grant[m] & o_awready & !wfifo_full; zero for non-granted masters.
- Each AW handshake pushes the granted index into the W-routing FIFO (axicb_scfifo, PASS_THRU=0). FIFO full blocks AW: o_awvalid=0, all i_awready=0.
- W: head index h selects the master. o_wvalid = i_wvalid[h] & !empty. i_wready[h] = o_wready & !empty. All other i_wready = 0. Payload and wlast muxed from h. Pop on o_wvalid & o_wready & o_wlast.
- W before AW: FIFO empty -> W held (ready 0) until the entry is visible.
- B: m = o_bch[AXI_ID_W-1 -: $clog2(MST_NB)]. i_bvalid[m] = o_bvalid, others 0. o_bready = i_bready[m]. i_bch = o_bch unmodified.
- Out-of-range m (MST_NB not a power of 2): o_bready=1, response dropped, no i_bvalid.

## Timing
- AW without macro: combinational, 0-cycle latency from i_awvalid to o_awvalid.
- FIFO push-to-head visibility is 1 cycle. The first W beat of a burst whose AW handshakes in cycle t can transfer in cycle t+1 at the earliest.
- W and B paths: purely combinational, 0 latency, one beat per cycle.
- Simultaneous push and pop: allowed when FIFO is neither empty nor full. Count is unchanged.
- areset mid-burst: FIFO contents lost. Upstream and slave must be reset together.

## Configuration
- AXICB_MST_SW_WR_AWREG_EN defined: 2-entry skid register slice on slave AW.
  - o_awvalid/o_awch are registered: +1 cycle latency, full throughput.
  - Arbiter handshakes against the slice's not-full. HOLD is entered only when the slice is full.
  - FIFO push happens on the upstream handshake.
- Undefined: combinational path as above.

## Structure
- axicb_pkg holds:
  - the BRESP encodings (OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11);
  - the FSM state enum {ARB, HOLD};
  - a clog2-based master-index width function.
- Sub-module axicb_mst_wr_rr_arb: round-robin request/grant with pointer, freeze input and one-hot grant.
- axicb_scfifo is reused for the W-routing FIFO.

## Test plan
- Masters 0 and 2 assert AW together after reset, slave always ready: grant order 0,2,0,2. No AW handshake for master 1/3.
- Master 1 AW while o_awready=0 for 5 cycles, master 3 asserts meanwhile: grant stays 1 through HOLD. Master 3 is served next.
- Master 0 AW (len 3), then master 2 AW (len 1): W beats forwarded 4 from master 0, then 2 from master 2. Master 2 W ready stays 0 until master 0 wlast.
- Master 3 W valid 4 cycles before its AW: no W handshake until the cycle after the AW handshake.
- Fill FIFO with 2^WFIFO_DEPTH_W AWs, W withheld: next AW sees o_awvalid=0. One wlast pop re-enables AW next cycle.
- B with bid upper bits=2, bresp=2'b10: only i_bvalid[2]=1, i_bch={2'b10,bid}, o_bready follows i_bready[2].
